montgomery_mult_core: RTL and testbench
=======================================

MONTGOMERY_MULT_CORE -- requirements
Module: montgomery_mult_core

Interface
REQ-001 Parameter: RSA_BITS, default 1024, operand/modulus width N in bits.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 resetn  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  request: latch operands and begin one multiplication; honoured only in IDLE.
REQ-005 in_a  input  RSA_BITS  operand A, sampled on the accepted start edge.
REQ-006 in_b  input  RSA_BITS  operand B, sampled on the accepted start edge.
REQ-007 in_m  input  RSA_BITS  modulus M, sampled on the accepted start edge.
REQ-008 busy  output  1  high while in LOOP, SUB or DONE.
REQ-009 done  output  1  one-cycle pulse: result valid.
REQ-010 result  output  RSA_BITS  A*B*2^-N mod M; held stable from the done pulse until the next accepted start.

Function
REQ-011 The block SHALL compute the radix-2 bit-serial Montgomery product C = A*B*R^-1 mod M, with R = 2^N.
REQ-012 Caller preconditions: M odd, A < M, B < M; results for inputs outside these preconditions are undefined but SHALL NOT hang the FSM.
REQ-013 FSM states: IDLE, LOOP, SUB, DONE; encoding is free.
REQ-014 IDLE -> LOOP on a rising edge with start=1; that edge registers A, B, M, clears accumulator C (N+2 bits) and clears bit counter i.
REQ-015 In LOOP, each cycle SHALL perform: T = C + (A[i] ? B : 0); T = T + (T[0] ? M : 0); C <= T >> 1; i <= i+1.
REQ-016 Accumulator and intermediate sums SHALL be N+2 bits wide; no bit of T SHALL be truncated before the shift.
REQ-017 LOOP -> SUB after exactly N LOOP cycles (i = N-1 processed).
REQ-018 In SUB (one cycle): result <= (C >= M) ? C - M : C[N-1:0]; state -> DONE.
REQ-019 In DONE (one cycle): done = 1; state -> IDLE.
REQ-020 Latency: with start accepted at edge 0, done SHALL be high during the cycle after edge N+2, i.e. N+2 cycles total.
REQ-021 done SHALL be a registered output, high for exactly one cycle per accepted start.
REQ-022 start asserted while busy=1 SHALL be ignored: no operand re-latch, no restart, no extra done pulse.
REQ-023 start held high continuously SHALL start a new operation on the first edge in IDLE after each DONE (back-to-back operation, one idle cycle between).
REQ-024 Changes on in_a/in_b/in_m after the accepted start edge SHALL NOT affect the running computation.
REQ-025 result SHALL change only in SUB; it SHALL remain stable in IDLE, LOOP and DONE.

Reset
REQ-026 resetn=0 on a rising edge SHALL force state IDLE, C=0, i=0, result=0, done=0, busy=0.
REQ-027 Reset asserted mid-operation (any of LOOP/SUB/DONE) SHALL abort the operation; no done pulse SHALL follow; the next start after resetn=1 SHALL behave as from power-up.
REQ-028 start asserted while resetn=0 SHALL be ignored.

Verification
REQ-029 RSA_BITS=8, A=5, B=7, M=13 -> result=1, done high exactly 10 cycles after the start edge, one-cycle pulse.
REQ-030 RSA_BITS=8, M=13: (A=1,B=1) -> 3; (A=12,B=12) -> 3; (A=0,B=9) -> 0; final-subtraction path exercised.
REQ-031 RSA_BITS=1024, M=2^1024-1, A=1, B=1 -> result=1 after 1026 cycles; random A,B<M vs reference model (1000 vectors) all match.
REQ-032 RSA_BITS=8: start re-pulsed at cycle 3 of a running op with different operands -> single done, result of first operands only.
REQ-033 RSA_BITS=8: resetn low for one cycle at LOOP cycle 4 -> no done, result=0, busy=0; subsequent start A=5,B=7,M=13 -> result=1.
REQ-034 RSA_BITS=8: start held high for 30 cycles with A=5,B=7,M=13 -> done pulses at cycles 10 and 21, result=1 each time, stable between pulses.

Source files
------------

// File: rtl/montgomery_mult_core_if.sv
// Request/response bundle for the bit-serial Montgomery multiplier.
// The master drives operands and start; the core (slave) returns status and result.
interface montgomery_mult_core_if #(
    parameter int RSA_BITS = 1024
);
    logic                start;
    logic [RSA_BITS-1:0] in_a;
    logic [RSA_BITS-1:0] in_b;
    logic [RSA_BITS-1:0] in_m;
    logic                busy;
    logic                done;
    logic [RSA_BITS-1:0] result;

    modport master (
        output start, in_a, in_b, in_m,
        input  busy, done, result
    );

    modport slave (
        input  start, in_a, in_b, in_m,
        output busy, done, result
    );
endinterface

// File: rtl/montgomery_mult_core.sv
// Radix-2 bit-serial Montgomery multiplier: result = A*B*2^-N mod M.
// One operand bit per LOOP cycle, then a single conditional subtraction.
module montgomery_mult_core #(
    parameter int RSA_BITS = 1024
) (
    input  logic                  clk,
    input  logic                  resetn,
    montgomery_mult_core_if.slave bus
);
    localparam int N  = RSA_BITS;
    localparam int CW = N + 2;
    localparam int IW = $clog2(N) + 1;

    typedef enum logic [1:0] {IDLE, LOOP, SUB, DONE} state_t;

    typedef struct packed {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] m;
    } op_t;

    state_t        state, state_nx;
    op_t           op_q;
    logic [CW-1:0] c_q;
    logic [CW-1:0] t_add;
    logic [CW-1:0] t_red;
    logic [CW-1:0] c_sub;
    logic [CW-1:0] m_ext;
    logic [IW-1:0] i_q;
    logic [N-1:0]  result_q;
    logic          done_q;
    logic          last_bit;

    // op_q.a is shifted right each LOOP cycle, so bit 0 is always A[i].
    always_comb begin
        m_ext    = {2'b00, op_q.m};
        t_add    = c_q + (op_q.a[0] ? {2'b00, op_q.b} : '0);
        t_red    = t_add + (t_add[0] ? m_ext : '0);
        c_sub    = c_q - m_ext;
        last_bit = (i_q == IW'(N - 1));
    end

    always_ff @(posedge clk) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.start) state_nx = LOOP;
            LOOP:    if (last_bit)  state_nx = SUB;
            SUB:     state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            op_q     <= '0;
            c_q      <= '0;
            i_q      <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            // done lands in the IDLE cycle right after DONE, as a clean register.
            done_q <= (state == DONE);
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        op_q.a <= bus.in_a;
                        op_q.b <= bus.in_b;
                        op_q.m <= bus.in_m;
                        c_q    <= '0;
                        i_q    <= '0;
                    end
                end
                LOOP: begin
                    c_q    <= t_red >> 1;
                    op_q.a <= op_q.a >> 1;
                    i_q    <= i_q + IW'(1);
                end
                SUB: begin
                    result_q <= (c_q >= m_ext) ? c_sub[N-1:0] : c_q[N-1:0];
                end
                default: ;
            endcase
        end
    end

    assign bus.busy   = (state != IDLE);
    assign bus.done   = done_q;
    assign bus.result = result_q;
endmodule

// File: tb/tb_montgomery_mult_core.sv
// Directed bench for the Montgomery core: an 8-bit instance checked every cycle
// against a brute-force modular model, plus a 1024-bit instance with M = 2^1024-1.
module tb_montgomery_mult_core;
    localparam int N8 = 8;
    localparam int NW = 1024;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    montgomery_mult_core_if #(.RSA_BITS(N8)) ifc8 ();
    montgomery_mult_core_if #(.RSA_BITS(NW)) ifcw ();

    montgomery_mult_core #(.RSA_BITS(N8)) dut8 (.clk(clk), .resetn(resetn), .bus(ifc8));
    montgomery_mult_core #(.RSA_BITS(NW)) dutw (.clk(clk), .resetn(resetn), .bus(ifcw));

    int n_chk = 0;
    int n_fail = 0;
    int n_done_exp = 0;
    int n_done_got = 0;

    task automatic check(input string name, input logic [1023:0] act, input logic [1023:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Montgomery product by definition: the unique c < m with c*2^8 == a*b (mod m).
    function automatic logic [7:0] mont8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] m);
        int mi, ab;
        mi = int'(m);
        ab = (int'(a) * int'(b)) % mi;
        for (int c = 0; c < mi; c++)
            if (((c * 256) % mi) == ab) return 8'(c);
        return 8'd0;
    endfunction

    // Transaction-level model of the 8-bit instance: accept, wait N+2 edges, report.
    logic       m_act = 1'b0;
    int         m_cnt = 0;
    logic [7:0] la, lb, lm;
    logic [7:0] exp_res = 8'd0;
    logic       exp_done = 1'b0;

    always @(posedge clk) begin
        exp_done = 1'b0;
        if (!resetn) begin
            m_act   = 1'b0;
            exp_res = 8'd0;
        end else if (m_act) begin
            m_cnt++;
            if (m_cnt == N8 + 1) exp_res = mont8(la, lb, lm);
            if (m_cnt == N8 + 2) begin
                m_act    = 1'b0;
                exp_done = 1'b1;
                n_done_exp++;
            end
        end else if (ifc8.start) begin
            m_act = 1'b1;
            m_cnt = 0;
            la    = ifc8.in_a;
            lb    = ifc8.in_b;
            lm    = ifc8.in_m;
        end
    end

    always @(negedge clk) begin
        check("busy8", 1024'(ifc8.busy), 1024'(m_act));
        check("done8", 1024'(ifc8.done), 1024'(exp_done));
        check("result8", 1024'(ifc8.result), 1024'(exp_res));
        if (ifc8.done) n_done_got++;
    end

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] m,
                       input logic [7:0] exp, input string nm);
        int j;
        @(posedge clk); #2;
        ifc8.in_a = a; ifc8.in_b = b; ifc8.in_m = m; ifc8.start = 1'b1;
        @(posedge clk); #2;
        ifc8.start = 1'b0;
        ifc8.in_a = 8'($urandom); ifc8.in_b = 8'($urandom); ifc8.in_m = 8'($urandom);
        for (j = 0; j < 40; j++) begin
            @(negedge clk);
            if (ifc8.done) break;
        end
        check({nm, " latency"}, 1024'(j), 1024'(N8 + 2));
        check(nm, 1024'(ifc8.result), 1024'(exp));
    endtask

    task automatic opw(input logic [NW-1:0] a, input logic [NW-1:0] b, input string nm);
        int j;
        logic [2*NW-1:0] p;
        logic [NW-1:0]   mw;
        mw = '1;
        p  = ({{NW{1'b0}}, a} * {{NW{1'b0}}, b}) % {{NW{1'b0}}, mw};
        @(posedge clk); #2;
        ifcw.in_a = a; ifcw.in_b = b; ifcw.in_m = mw; ifcw.start = 1'b1;
        @(posedge clk); #2;
        ifcw.start = 1'b0;
        for (j = 0; j < 1100; j++) begin
            @(negedge clk);
            if (ifcw.done) break;
        end
        check({nm, " latency"}, 1024'(j), 1024'(NW + 2));
        check(nm, ifcw.result, p[NW-1:0]);
    endtask

    initial begin
        int j, d1, d2, nd;
        logic [NW-1:0] wa, wb;
        logic [7:0] ra, rb;

        ifcw.start = 1'b0; ifcw.in_a = '0; ifcw.in_b = '0; ifcw.in_m = '0;
        // start held during reset must be ignored
        ifc8.start = 1'b1; ifc8.in_a = 8'd5; ifc8.in_b = 8'd7; ifc8.in_m = 8'd13;
        repeat (4) @(posedge clk);
        #2 resetn = 1'b1; ifc8.start = 1'b0;
        @(negedge clk);
        check("reset busy", 1024'(ifc8.busy), 1024'(0));
        check("reset done", 1024'(ifc8.done), 1024'(0));
        check("reset result", 1024'(ifc8.result), 1024'(0));
        check("reset busyw", 1024'(ifcw.busy), 1024'(0));

        check("model 5*7", 1024'(mont8(8'd5, 8'd7, 8'd13)), 1024'(1));
        check("model 1*1", 1024'(mont8(8'd1, 8'd1, 8'd13)), 1024'(3));
        check("model 12*12", 1024'(mont8(8'd12, 8'd12, 8'd13)), 1024'(3));
        check("model 0*9", 1024'(mont8(8'd0, 8'd9, 8'd13)), 1024'(0));

        op8(8'd5, 8'd7, 8'd13, 8'd1, "5*7 m13");
        op8(8'd1, 8'd1, 8'd13, 8'd3, "1*1 m13");
        op8(8'd12, 8'd12, 8'd13, 8'd3, "12*12 m13");
        op8(8'd0, 8'd9, 8'd13, 8'd0, "0*9 m13");

        // re-pulsed start mid-operation is ignored
        @(posedge clk); #2;
        ifc8.in_a = 8'd5; ifc8.in_b = 8'd7; ifc8.in_m = 8'd13; ifc8.start = 1'b1;
        @(posedge clk); #2 ifc8.start = 1'b0;
        repeat (2) @(posedge clk);
        #2 ifc8.in_a = 8'd1; ifc8.in_b = 8'd1; ifc8.start = 1'b1;
        @(posedge clk); #2 ifc8.start = 1'b0;
        nd = 0;
        for (j = 0; j < 30; j++) begin
            @(negedge clk);
            if (ifc8.done) nd++;
        end
        check("restart dones", 1024'(nd), 1024'(1));
        check("restart result", 1024'(ifc8.result), 1024'(1));

        // reset for one cycle in the middle of LOOP
        @(posedge clk); #2;
        ifc8.in_a = 8'd5; ifc8.in_b = 8'd7; ifc8.in_m = 8'd13; ifc8.start = 1'b1;
        @(posedge clk); #2 ifc8.start = 1'b0;
        repeat (3) @(posedge clk);
        #2 resetn = 1'b0;
        @(posedge clk); #2 resetn = 1'b1;
        nd = 0;
        for (j = 0; j < 20; j++) begin
            @(negedge clk);
            if (ifc8.done) nd++;
        end
        check("abort dones", 1024'(nd), 1024'(0));
        check("abort busy", 1024'(ifc8.busy), 1024'(0));
        check("abort result", 1024'(ifc8.result), 1024'(0));
        op8(8'd5, 8'd7, 8'd13, 8'd1, "after abort");

        // start held high: back-to-back operations
        @(posedge clk); #2;
        ifc8.in_a = 8'd5; ifc8.in_b = 8'd7; ifc8.in_m = 8'd13; ifc8.start = 1'b1;
        @(posedge clk);
        d1 = -1; d2 = -1; nd = 0;
        for (j = 0; j < 30; j++) begin
            @(negedge clk);
            if (ifc8.done) begin
                if (nd == 0) d1 = j; else d2 = j;
                nd++;
                check("held result", 1024'(ifc8.result), 1024'(1));
            end
        end
        ifc8.start = 1'b0;
        check("held dones", 1024'(nd), 1024'(2));
        check("held first", 1024'(d1), 1024'(10));
        check("held second", 1024'(d2), 1024'(21));
        for (j = 0; j < 20; j++) begin
            @(negedge clk);
            if (ifc8.done) break;
        end
        check("held drain", 1024'(j < 20), 1024'(1));

        for (int a = 0; a < 13; a++)
            for (int b = 0; b < 13; b++)
                op8(8'(a), 8'(b), 8'd13, mont8(8'(a), 8'(b), 8'd13), "sweep m13");
        for (int k = 0; k < 40; k++) begin
            ra = 8'($urandom_range(0, 254));
            rb = 8'($urandom_range(0, 254));
            op8(ra, rb, 8'd255, mont8(ra, rb, 8'd255), "rand m255");
            ra = 8'($urandom_range(0, 250));
            rb = 8'($urandom_range(0, 250));
            op8(ra, rb, 8'd251, mont8(ra, rb, 8'd251), "rand m251");
        end

        opw(NW'(1), NW'(1), "wide 1*1");
        check("wide 1*1 literal", ifcw.result, 1024'(1));
        for (int k = 0; k < 15; k++) begin
            for (int w = 0; w < NW / 32; w++) begin
                wa[w*32 +: 32] = $urandom;
                wb[w*32 +: 32] = $urandom;
            end
            wa[NW-1] = 1'b0;
            wb[NW-1] = 1'b0;
            opw(wa, wb, "wide rand");
        end

        @(negedge clk);
        check("done count", 1024'(n_done_got), 1024'(n_done_exp));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
